washer_panel: RTL and testbench
===============================

# washer_panel

Front-panel controller for the washing-machine design: debounces the raw panel buttons and door/soap switches, keeps the selected wash program, and drives the program controller's `program_selection`, `start`, `doorclosed` and `soap` inputs. It also receives `program_done` and `soap_warning` from the controller and turns them into door-lock, busy and beeper outputs. It sits between the physical panel and the program FSM.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles needed before a debounced input changes (≥1).
- `BEEP_CYCLES`, default 8: length of a beep burst in cycles (≥1).
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `power` in 1: mains enable (already clean, not debounced).
- `btn_select_raw` in 1: raw program-select button, high = pressed.
- `btn_start_raw` in 1: raw start button, high = pressed.
- `door_sw_raw` in 1: raw door switch, high = closed.
- `soap_sw_raw` in 1: raw soap-drawer switch, high = soap present.
- `program_done` in 1: one-cycle completion pulse from the program FSM.
- `soap_warning` in 1: soap-missing indication from the program FSM.
- `program_selection` out 3: program code to the FSM (0 cold, 1 hot, 2 rinse+dry, 3 dry only, 4 warm).
- `start` out 1: one-cycle start pulse to the FSM.
- `doorclosed` out 1: debounced door switch.
- `soap` out 1: debounced soap switch.
- `door_lock` out 1: door solenoid lock.
- `busy` out 1: a program is running.
- `led_program` out 5: one-hot indicator of `program_selection`.
- `beep` out 1: buzzer drive.

## Operation
- Debounce, applied to each of the 4 raw inputs:
  - 2-flop synchroniser feeds a counter.
  - The counter increments while the synchronised value differs from the debounced value and clears when they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced value flips and the counter clears.
  - Press event = debounced button rising edge, high for one cycle.
- States: OFF, SELECT, RUNNING, DONE.
- OFF:
  - All outputs 0 except `led_program`, which is 00001.
  - `program_selection` is forced to 0.
  - `power`=1 → SELECT.
- SELECT:
  - A select press increments `program_selection`, wrapping 4→0.
  - A start press with `doorclosed`=1 → pulse `start`, go to RUNNING.
  - A start press with `doorclosed`=0 → beep burst, stay in SELECT.
- RUNNING:
  - `busy`=1 and `door_lock`=1.
  - Select and start presses are ignored.
  - `program_selection` is frozen.
  - `beep` = `soap_warning` while no burst is active.
  - `program_done` → DONE.
- DONE:
  - `door_lock`=1; `busy`=0.
  - A `BEEP_CYCLES` burst plays.
  - When the burst ends → SELECT, with `door_lock`=0 and the selection retained.
- Any state with `power`=0 → OFF on the next edge. This takes priority over every other event, including `program_done` in the same cycle.
- Select and start pressed in the same SELECT cycle: start wins and uses the un-incremented selection.
- A new burst request during an active burst restarts the burst counter.
- `doorclosed` and `soap` pass through from the debouncers in every state, but are forced to 0 in OFF.
- `rst`:
  - Clears the state to OFF and all counters to 0.
  - Clears the debounced values and synchronisers to 0.
  - Sets `start`, `busy`, `door_lock`, `beep`, `program_selection` to 0 and `led_program` to 00001.
- Reset mid-run returns the block to OFF with no `start` issued.

## Timing
- Raw change first sampled at edge 1. The debounced value flips at edge `DEBOUNCE_CYCLES`+2 if the raw value stays stable throughout.
- `start` is registered and high for exactly the one cycle after edge `DEBOUNCE_CYCLES`+3. The state is RUNNING on that same edge.
- A select press updates `program_selection` and `led_program` at edge `DEBOUNCE_CYCLES`+3.
- Beep bursts are exactly `BEEP_CYCLES` cycles long, starting the cycle after the triggering event.
- DONE lasts `BEEP_CYCLES`+1 cycles.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles after synchronisation produces no change.

## Structure
- Shared package `washer_pkg`:
  - Program codes COLD_WASH=0, HOT_WASH=1, RINSING_DRY=2, ONLY_DRY=3, WARM_WASH=4.
  - NUM_PROGRAMS=5.
  - Panel state encoding.
- Sub-module `debounce`, instanced 4 times. It contains the synchroniser, the counter and the registered debounced output, and is parameterised by `DEBOUNCE_CYCLES`.
- The top level holds the panel FSM, the selection register, the beep counter and the one-hot decode.

## Test plan
- Reset then `power`=1, 3 clean select presses → `program_selection`=3, `led_program`=01000. A further 2 presses → 0 (wrap).
- Door closed, start held 10 cycles with D=4 → exactly one `start` pulse, 7 cycles after start is first sampled. `busy`=`door_lock`=1, and select presses are then ignored.
- Door open, start press → no `start` pulse; `beep` high for exactly 8 cycles; state stays SELECT.
- Start button with 3-cycle glitches repeating, D=4 → no `start`. A stable 5-cycle press → one pulse.
- RUNNING, `soap_warning`=1 for 20 cycles → `beep` follows it. Then `program_done` → 8-cycle beep, `door_lock` released afterwards, selection unchanged.
- RUNNING, `power`=0 in the same cycle as `program_done` → OFF next edge, all outputs 0, `program_selection`=0. Also `rst` mid-run gives the same reset values.

Source files
------------

// File: rtl/washer_panel_pkg.sv
// Shared definitions for the washing-machine front panel: program codes,
// panel FSM state encoding and small program-selection helpers.
// Latency: n/a (package). Backpressure: n/a.
package washer_pkg;

   localparam int NUM_PROGRAMS = 5;

   localparam logic [2:0] COLD_WASH   = 3'd0;
   localparam logic [2:0] HOT_WASH    = 3'd1;
   localparam logic [2:0] RINSING_DRY = 3'd2;
   localparam logic [2:0] ONLY_DRY    = 3'd3;
   localparam logic [2:0] WARM_WASH   = 3'd4;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_SELECT  = 2'd1,
      ST_RUNNING = 2'd2,
      ST_DONE    = 2'd3
   } panel_state_t;

   // Next program in the select rotation; WARM_WASH wraps back to COLD_WASH.
   function automatic logic [2:0] next_program(input logic [2:0] p);
      return (p == WARM_WASH) ? COLD_WASH : p + 3'd1;
   endfunction

   // One-hot panel LED pattern for a program code.
   function automatic logic [NUM_PROGRAMS-1:0] program_onehot(input logic [2:0] p);
      logic [NUM_PROGRAMS-1:0] led;
      case (p)
         COLD_WASH:   led = 5'b00001;
         HOT_WASH:    led = 5'b00010;
         RINSING_DRY: led = 5'b00100;
         ONLY_DRY:    led = 5'b01000;
         WARM_WASH:   led = 5'b10000;
         default:     led = 5'b00001;
      endcase
      return led;
   endfunction

endpackage

// File: rtl/washer_panel_debounce.sv
// Switch debouncer: 2-flop synchroniser, stability counter, registered level.
// Latency: a clean change appears on level DEBOUNCE_CYCLES+2 edges after first sample.
// Backpressure: none; free-running on every clock.
// Ports: clk, rst (sync, active high), raw (asynchronous switch), level (debounced).
module debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            // This edge is the DEBOUNCE_CYCLES-th consecutive mismatch.
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/washer_panel.sv
// Washer front panel: debounces switches, holds program selection, drives start/lock/busy/beep.
// Latency: button press to start pulse / selection change is DEBOUNCE_CYCLES+3 edges.
// Backpressure: none; presses outside SELECT are dropped.
// Ports: clk, rst, power, four raw switches, program_done/soap_warning from the program FSM;
//        program_selection, start, doorclosed, soap to the FSM; door_lock, busy, led_program, beep.
module washer_panel
   import washer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int BEEP_CYCLES     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    power,
   input  logic                    btn_select_raw,
   input  logic                    btn_start_raw,
   input  logic                    door_sw_raw,
   input  logic                    soap_sw_raw,
   input  logic                    program_done,
   input  logic                    soap_warning,
   output logic [2:0]              program_selection,
   output logic                    start,
   output logic                    doorclosed,
   output logic                    soap,
   output logic                    door_lock,
   output logic                    busy,
   output logic [NUM_PROGRAMS-1:0] led_program,
   output logic                    beep
);

   localparam int             BCW       = $clog2(BEEP_CYCLES + 1);
   localparam logic [BCW-1:0] BEEP_LOAD = BCW'(BEEP_CYCLES);

   logic sel_lvl, start_lvl, door_lvl, soap_lvl;
   logic sel_prev, start_prev;
   logic sel_press, start_press;

   panel_state_t   state, state_next;
   logic [2:0]     sel_q, sel_next;
   logic [BCW-1:0] burst_q, burst_next;
   logic           start_q, start_next;

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_select (
      .clk(clk), .rst(rst), .raw(btn_select_raw), .level(sel_lvl));
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .clk(clk), .rst(rst), .raw(btn_start_raw), .level(start_lvl));
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_door (
      .clk(clk), .rst(rst), .raw(door_sw_raw), .level(door_lvl));
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_soap (
      .clk(clk), .rst(rst), .raw(soap_sw_raw), .level(soap_lvl));

   // Press events: one cycle on the debounced rising edge.
   assign sel_press   = sel_lvl & ~sel_prev;
   assign start_press = start_lvl & ~start_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_OFF;
         sel_q      <= COLD_WASH;
         burst_q    <= '0;
         start_q    <= 1'b0;
         sel_prev   <= 1'b0;
         start_prev <= 1'b0;
      end else begin
         state      <= state_next;
         sel_q      <= sel_next;
         burst_q    <= burst_next;
         start_q    <= start_next;
         sel_prev   <= sel_lvl;
         start_prev <= start_lvl;
      end
   end

   always_comb begin
      state_next = state;
      sel_next   = sel_q;
      burst_next = (burst_q == '0) ? '0 : burst_q - BCW'(1);
      start_next = 1'b0;

      case (state)
         ST_OFF: begin
            sel_next   = COLD_WASH;
            burst_next = '0;
            state_next = ST_SELECT;
         end
         ST_SELECT: begin
            // Start outranks select, so a simultaneous select is discarded.
            if (start_press) begin
               if (door_lvl) begin
                  start_next = 1'b1;
                  state_next = ST_RUNNING;
               end else begin
                  burst_next = BEEP_LOAD;
               end
            end else if (sel_press) begin
               sel_next = next_program(sel_q);
            end
         end
         ST_RUNNING: begin
            if (program_done) begin
               state_next = ST_DONE;
               burst_next = BEEP_LOAD;
            end
         end
         ST_DONE: begin
            // One extra cycle after the burst drains keeps the door locked.
            if (burst_q == '0) state_next = ST_SELECT;
         end
         default: state_next = ST_OFF;
      endcase

      // Mains off wins over everything, including a same-cycle program_done.
      if (!power) begin
         state_next = ST_OFF;
         sel_next   = COLD_WASH;
         burst_next = '0;
         start_next = 1'b0;
      end

      program_selection = sel_q;
      led_program       = program_onehot(sel_q);
      start             = start_q;
      busy              = (state == ST_RUNNING);
      door_lock         = (state == ST_RUNNING) || (state == ST_DONE);
      doorclosed        = (state != ST_OFF) && door_lvl;
      soap              = (state != ST_OFF) && soap_lvl;
      beep              = (state != ST_OFF) &&
                          ((burst_q != '0) || ((state == ST_RUNNING) && soap_warning));
   end

endmodule

// File: tb/tb_washer_panel.sv
// Directed bench for washer_panel: table of select presses plus hand-written sequences
// for start timing, door-open beep, glitch rejection, soap warning, done, power-off and reset.
// Uses default parameters DEBOUNCE_CYCLES=4, BEEP_CYCLES=8.
module tb_washer_panel;

   logic       clk = 1'b0;
   logic       rst, power, btn_select_raw, btn_start_raw, door_sw_raw, soap_sw_raw;
   logic       program_done, soap_warning;
   logic [2:0] program_selection;
   logic       start, doorclosed, soap, door_lock, busy, beep;
   logic [4:0] led_program;

   int checks   = 0;
   int failures = 0;

   washer_panel dut (
      .clk(clk), .rst(rst), .power(power),
      .btn_select_raw(btn_select_raw), .btn_start_raw(btn_start_raw),
      .door_sw_raw(door_sw_raw), .soap_sw_raw(soap_sw_raw),
      .program_done(program_done), .soap_warning(soap_warning),
      .program_selection(program_selection), .start(start),
      .doorclosed(doorclosed), .soap(soap), .door_lock(door_lock),
      .busy(busy), .led_program(led_program), .beep(beep));

   always #5 clk = ~clk;

   typedef struct {
      logic       do_sel;
      logic [2:0] exp_sel;
      logic [4:0] exp_led;
   } vec_t;

   vec_t tbl[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive buttons high for 'hold' sampled edges, run 'total' edges, count start pulses and beep cycles.
   task automatic run_btn(input logic s, input logic t, input int hold, input int total,
                          output int starts, output int beeps);
      starts = 0;
      beeps  = 0;
      btn_select_raw = s;
      btn_start_raw  = t;
      for (int k = 1; k <= total; k++) begin
         tick();
         if (k == hold) begin
            btn_select_raw = 1'b0;
            btn_start_raw  = 1'b0;
         end
         starts += int'(start);
         beeps  += int'(beep);
      end
   endtask

   task automatic check_off(input string tag);
      check({tag, "_sel"},   32'(program_selection), 32'd0);
      check({tag, "_led"},   32'(led_program),       32'b00001);
      check({tag, "_start"}, 32'(start),             32'd0);
      check({tag, "_busy"},  32'(busy),              32'd0);
      check({tag, "_lock"},  32'(door_lock),         32'd0);
      check({tag, "_beep"},  32'(beep),              32'd0);
      check({tag, "_door"},  32'(doorclosed),        32'd0);
      check({tag, "_soap"},  32'(soap),              32'd0);
   endtask

   initial begin
      int starts, beeps;

      tbl[0] = '{1'b0, 3'd0, 5'b00001};
      tbl[1] = '{1'b1, 3'd1, 5'b00010};
      tbl[2] = '{1'b1, 3'd2, 5'b00100};
      tbl[3] = '{1'b1, 3'd3, 5'b01000};
      tbl[4] = '{1'b1, 3'd4, 5'b10000};
      tbl[5] = '{1'b1, 3'd0, 5'b00001};
      tbl[6] = '{1'b1, 3'd1, 5'b00010};
      tbl[7] = '{1'b1, 3'd2, 5'b00100};

      rst = 1'b1; power = 1'b0; btn_select_raw = 1'b0; btn_start_raw = 1'b0;
      door_sw_raw = 1'b0; soap_sw_raw = 1'b0; program_done = 1'b0; soap_warning = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check_off("reset");

      // Selection rotation, including wrap from warm back to cold.
      power = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].do_sel) run_btn(1'b1, 1'b0, 6, 14, starts, beeps);
         else repeat (2) tick();
         check($sformatf("tbl%0d_sel", i), 32'(program_selection), 32'(tbl[i].exp_sel));
         check($sformatf("tbl%0d_led", i), 32'(led_program), 32'(tbl[i].exp_led));
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'd0);
      end

      // Door open: start press beeps for 8 cycles, no start, still selecting.
      run_btn(1'b0, 1'b1, 6, 25, starts, beeps);
      check("dooropen_starts", 32'(starts), 32'd0);
      check("dooropen_beeps",  32'(beeps),  32'd8);
      check("dooropen_busy",   32'(busy),   32'd0);
      check("dooropen_sel",    32'(program_selection), 32'd2);

      // Close door and add soap; both pass through once debounced.
      door_sw_raw = 1'b1;
      soap_sw_raw = 1'b1;
      repeat (8) tick();
      check("door_closed", 32'(doorclosed), 32'd1);
      check("soap_present", 32'(soap), 32'd1);

      // Start held 10 cycles: single pulse after edge 7, running from that edge.
      btn_start_raw = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("held_start_k%0d", k), 32'(start), 32'(k == 7));
         if (k == 7) begin
            check("held_busy", 32'(busy), 32'd1);
            check("held_lock", 32'(door_lock), 32'd1);
         end
      end
      btn_start_raw = 1'b0;
      run_btn(1'b1, 1'b0, 6, 14, starts, beeps);
      check("run_sel_ignored", 32'(program_selection), 32'd2);
      check("run_no_restart",  32'(starts), 32'd0);

      // Soap warning drives beep while running.
      soap_warning = 1'b1;
      beeps = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         beeps += int'(beep);
      end
      check("soapwarn_beeps", 32'(beeps), 32'd20);
      soap_warning = 1'b0;
      tick();
      check("soapwarn_clear", 32'(beep), 32'd0);

      // Completion: 8-cycle burst, lock held for 9 cycles, then back to select.
      program_done = 1'b1;
      tick();
      program_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("done_beep_%0d", i), 32'(beep), 32'(i < 8));
         check($sformatf("done_lock_%0d", i), 32'(door_lock), 32'(i < 9));
         tick();
      end
      check("done_busy", 32'(busy), 32'd0);
      check("done_sel",  32'(program_selection), 32'd2);

      // 3-cycle glitches never qualify; a stable 5-cycle press does.
      starts = 0;
      for (int r = 0; r < 4; r++) begin
         btn_start_raw = 1'b1;
         repeat (3) begin tick(); starts += int'(start); end
         btn_start_raw = 1'b0;
         repeat (3) begin tick(); starts += int'(start); end
      end
      repeat (6) begin tick(); starts += int'(start); end
      check("glitch_starts", 32'(starts), 32'd0);
      run_btn(1'b0, 1'b1, 5, 12, starts, beeps);
      check("stable5_starts", 32'(starts), 32'd1);
      check("stable5_busy",   32'(busy), 32'd1);

      // Power loss in the same cycle as program_done: OFF wins.
      power = 1'b0;
      program_done = 1'b1;
      tick();
      program_done = 1'b0;
      check_off("poweroff");
      repeat (3) tick();
      check("poweroff_stays_lock", 32'(door_lock), 32'd0);

      // Power back on; select+start together: start wins with the old selection.
      power = 1'b1;
      tick();
      run_btn(1'b1, 1'b0, 6, 14, starts, beeps);
      check("repower_sel", 32'(program_selection), 32'd1);
      run_btn(1'b1, 1'b1, 6, 12, starts, beeps);
      check("both_starts", 32'(starts), 32'd1);
      check("both_sel",    32'(program_selection), 32'd1);
      check("both_busy",   32'(busy), 32'd1);

      // Reset mid-run.
      rst = 1'b1;
      tick();
      check_off("midrst");
      rst = 1'b0;
      starts = 0;
      repeat (5) begin tick(); starts += int'(start); end
      check("midrst_no_start", 32'(starts), 32'd0);
      check("midrst_busy",     32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
